// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin share of one multiplier; req_valid/req_ready/req_a/req_b in, mul_a/mul_b/mul_out to multiplier, res_valid/res_ready/res_id/res_data out, op_count of drained results
module mult_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 32,
  parameter int ID_WIDTH  = $clog2(NUM_REQ),
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic [A_WIDTH-1:0]           mul_a,
  output logic [B_WIDTH-1:0]           mul_b,
  input  logic [OUT_WIDTH-1:0]         mul_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ID_WIDTH-1:0]          res_id,
  output logic [OUT_WIDTH-1:0]         res_data,
  output logic [CNT_WIDTH-1:0]         op_count
);
  localparam logic [ID_WIDTH:0]   NR   = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(NUM_REQ-1);
  logic [ID_WIDTH-1:0] ptr, g, idx;
  logic [ID_WIDTH:0]   j;
  logic                gnt, slot_free, accept;
  always_comb begin
    gnt = 1'b0;
    g   = '0;
    j   = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j   = {1'b0, ptr} + (ID_WIDTH+1)'(k);
      idx = (j >= NR) ? ID_WIDTH'(j - NR) : j[ID_WIDTH-1:0];
      if (!gnt && req_valid[idx]) begin
        gnt = 1'b1;
        g   = idx;
      end
    end
  end
  assign slot_free = !res_valid || res_ready;
  assign accept    = gnt && slot_free;
  assign req_ready = accept ? (NUM_REQ'(1) << g) : '0;
  assign mul_a     = gnt ? req_a[g*A_WIDTH +: A_WIDTH] : '0;
  assign mul_b     = gnt ? req_b[g*B_WIDTH +: B_WIDTH] : '0;
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      op_count  <= '0;
      ptr       <= '0;
    end else begin
      if (res_valid && res_ready) op_count <= op_count + CNT_WIDTH'(1);
      if (accept) begin
        res_valid <= 1'b1;
        res_id    <= g;
        res_data  <= mul_out;
        ptr       <= (g == LAST) ? '0 : g + 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule
